r2sdf_bf_stage: RTL and testbench
=================================

// Module: r2sdf_bf_stage
// PURPOSE
//  Parametrised radix-2 single-path delay-feedback (R2SDF) butterfly stage for the streaming FFT.
//  Produces both the sum (x[n]+x[n+D]) and difference (x[n]-x[n+D]) halves in natural stream order.
//  Adds a valid/ready handshake, frame sync, optional 1-bit scaling and an explicit drain.
//  Instances are chained per stage; the twiddle multiplier sits between stages, outside this block.
// PARAMETERS
//  DATA_WIDTH  16  signed input width (re and im each)
//  N_POINTS    16  FFT size, power of two, >=2
//  STAGE       0   stage index; delay depth D = N_POINTS >> (STAGE+1), D>=1
//  SCALE       1   1: outputs are >>1 with round-half-up, OUT_W=DATA_WIDTH; 0: full growth, OUT_W=DATA_WIDTH+1
// PORTS
//  clk       in   1           clock, rising edge
//  rst       in   1           asynchronous active-low reset
//  in_valid  in   1           input sample valid
//  in_ready  out  1           stage accepts a sample (accept = in_valid & in_ready)
//  in_sof    in   1           marks first sample of a frame; qualified by accept
//  in_re     in   DATA_WIDTH  signed real input
//  in_im     in   DATA_WIDTH  signed imag input
//  flush     in   1           level request: emit stored differences without new input
//  out_valid out  1           output sample valid (no backpressure from downstream)
//  out_sof   out  1           first output of a frame
//  out_re    out  OUT_W       signed real output
//  out_im    out  OUT_W       signed imag output
//  err_sync  out  1           one-cycle pulse: in_sof arrived with cnt!=0
// BEHAVIOUR
//  - Reset: all outputs 0 except in_ready=1; cnt=0, pend=0, state=RUN, delay line cleared.
//  - cnt: 0..2D-1, advances by one per accept, wraps to 0. phase = (cnt>=D); idx = cnt mod D.
//  - Accept, phase 0: out = dly[idx] (difference from the previous frame); dly[idx] <= sext(x).
//    out_valid=pend, where pend means a compute half has completed that has not yet been output.
//  - Accept, phase 1: out = dly[idx] + x; dly[idx] <= dly[idx] - x; out_valid=1. pend set when cnt wraps.
//  - Outputs registered: result appears the cycle after the accept. Per-sample latency is D accepts plus 1 clk.
//  - out_sof=1 on the first phase-1 output of each frame.
//  - Arithmetic: sign-extend to DATA_WIDTH+1 and store full width in dly.
//    SCALE=1: out = (v+1)>>>1. Add/sub never overflows at DATA_WIDTH+1.
//  - States: RUN, DRAIN.
//    RUN->DRAIN when flush=1, cnt==0 and pend=1. In that cycle in_ready=0 and flush takes priority over in_valid.
//    DRAIN: in_ready=0. Emits dly[0..D-1] one per clk with out_valid=1.
//    DRAIN->RUN after D outputs, clearing pend.
//    flush with pend=0 or cnt!=0 is held off until the condition holds. No effect when pend=0 at cnt==0.
//  - in_sof accepted with cnt!=0: err_sync pulses, pend cleared, the sample is treated as cnt=0 (resync).
//    in_sof at cnt==0 is normal.
//  - Stall (in_valid=0 in RUN): nothing advances; out_valid=0 that cycle.
//  - Reset mid-frame or mid-DRAIN: immediate return to reset state; in-flight data discarded.
//  - D=1 (last stage): idx width forced to 1 bit, always 0.
// STRUCTURE
//  - fft_pkg: function sdf_depth(N_POINTS,STAGE), typedef enum {RUN,DRAIN} sdf_state_e,
//    typedef cplx_t (re/im) parameterised by width.
//  - Sub-module fft_delay_line: D-entry complex circular buffer, async reset, one read and one write per clk
//    at the same index (read-before-write).
//  - Top: counter/FSM, add/sub, scaling, output registers.
// TESTING (N_POINTS=4, STAGE=0, D=2 unless stated)
//  1. SCALE=0, accept 1,2,3,4 (im=0, sof on 1) -> outs 4,6 (sof on 4). Then flush -> outs -2,-2, then in_ready=1.
//  2. SCALE=0, two back-to-back frames 1,2,3,4 | 5,6,7,9 -> 4,6,-2,-2,12,15 then flush -> -2,-3.
//  3. SCALE=1, DATA_WIDTH=16: 32767,32767,32767,32767 -> 32767 twice; -32768 x4 -> -32768, no wrap.
//     Pair 3,0 -> (3+1)>>>1 = 2.
//  4. Stalls: same data as test 1 with in_valid gaps of 0-3 random cycles -> identical output sequence,
//     out_valid only on accept cycles.
//  5. in_sof on the 2nd sample of a frame -> err_sync pulses once, cnt resyncs, no stale differences emitted.
//  6. Reset asserted during DRAIN after one output -> all outputs 0, in_ready=1;
//     next frame 1,2,3,4 -> 4,6 exactly as test 1.

Source files
------------

// File: rtl/fft_pkg.sv
// Shared types and helpers for the streaming radix-2 SDF FFT stages.
package fft_pkg;

  typedef enum logic {RUN, DRAIN} sdf_state_e;

  function automatic int unsigned sdf_depth(input int unsigned n_points, input int unsigned stage);
    return n_points >> (stage + 1);
  endfunction

  // The last stage has D=1 and still needs a 1-bit index.
  function automatic int unsigned sdf_idx_w(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/fft_delay_line.sv
// D-entry complex circular buffer: one read and one write per clock at the same index, read-before-write.
module fft_delay_line #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned WIDTH = 34,
  parameter int unsigned IDX_W = 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             we_i,
  input  logic [IDX_W-1:0] idx_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic [WIDTH-1:0] rdata_o
);

  if (DEPTH == 1) begin : g_single
    logic [WIDTH-1:0] mem_q;
    logic             unused_idx;

    assign unused_idx = ^idx_i;
    assign rdata_o    = mem_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni)   mem_q <= '0;
      else if (we_i) mem_q <= wdata_i;
    end
  end else begin : g_multi
    logic [WIDTH-1:0] mem_q [DEPTH];

    assign rdata_o = mem_q[idx_i];

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      end else if (we_i) begin
        mem_q[idx_i] <= wdata_i;
      end
    end
  end

endmodule

// File: rtl/r2sdf_bf_stage.sv
// Radix-2 single-path delay-feedback butterfly stage with valid/ready input, frame sync,
// optional 1-bit round-half-up scaling and an explicit drain of the stored differences.
module r2sdf_bf_stage
  import fft_pkg::*;
#(
  parameter  int unsigned DATA_WIDTH = 16,
  parameter  int unsigned N_POINTS   = 16,
  parameter  int unsigned STAGE      = 0,
  parameter  int unsigned SCALE      = 1,
  localparam int unsigned OUT_W      = (SCALE != 0) ? DATA_WIDTH : DATA_WIDTH + 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic                         in_sof,
  input  logic signed [DATA_WIDTH-1:0] in_re,
  input  logic signed [DATA_WIDTH-1:0] in_im,
  input  logic                         flush,
  output logic                         out_valid,
  output logic                         out_sof,
  output logic signed [OUT_W-1:0]      out_re,
  output logic signed [OUT_W-1:0]      out_im,
  output logic                         err_sync
);

  localparam int unsigned D  = sdf_depth(N_POINTS, STAGE);
  localparam int unsigned EW = DATA_WIDTH + 1;
  localparam int unsigned IW = sdf_idx_w(D);
  localparam int unsigned CW = $clog2(2 * D);

  typedef struct packed {
    logic signed [EW-1:0] re;
    logic signed [EW-1:0] im;
  } cplx_t;

  sdf_state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d, ecnt;
  logic pend_q, pend_d, pend_base;
  logic flush_go, accept, resync, phase, dl_we;
  logic [IW-1:0] idx;
  cplx_t x_ext, rd, wr, res;
  logic v_d, sof_d, err_d;
  logic signed [EW:0] re_rnd, im_rnd;
  logic signed [OUT_W-1:0] out_re_d, out_im_d;
  logic out_valid_q, out_sof_q, err_sync_q;
  logic signed [OUT_W-1:0] out_re_q, out_im_q;

  assign flush_go  = (state_q == RUN) && flush && (cnt_q == '0) && pend_q;
  assign in_ready  = (state_q == RUN) && !flush_go;
  assign accept    = in_valid && in_ready;
  // A misplaced sof restarts the frame: this sample is processed as if cnt were 0.
  assign resync    = accept && in_sof && (cnt_q != '0);
  assign ecnt      = resync ? '0 : cnt_q;
  assign phase     = ecnt[CW-1];
  assign idx       = (D == 1) ? '0 : IW'(ecnt);
  assign pend_base = resync ? 1'b0 : pend_q;
  assign x_ext     = '{re: EW'(in_re), im: EW'(in_im)};

  fft_delay_line #(.DEPTH(D), .WIDTH(2 * EW), .IDX_W(IW)) u_dly (
    .clk_i  (clk),
    .rst_ni (rst),
    .we_i   (dl_we),
    .idx_i  (idx),
    .wdata_i(wr),
    .rdata_o(rd)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pend_d  = pend_q;
    dl_we   = 1'b0;
    wr      = rd;
    res     = rd;
    v_d     = 1'b0;
    sof_d   = 1'b0;
    err_d   = 1'b0;
    unique case (state_q)
      RUN: begin
        if (flush_go) begin
          state_d = DRAIN;
        end else if (accept) begin
          err_d = resync;
          dl_we = 1'b1;
          cnt_d = ecnt + CW'(1);
          if (!phase) begin
            wr     = x_ext;
            v_d    = pend_base;
            pend_d = (idx == IW'(D - 1)) ? 1'b0 : pend_base;
          end else begin
            res.re = rd.re + x_ext.re;
            res.im = rd.im + x_ext.im;
            wr.re  = rd.re - x_ext.re;
            wr.im  = rd.im - x_ext.im;
            v_d    = 1'b1;
            sof_d  = (idx == '0);
            if (ecnt == CW'(2 * D - 1)) pend_d = 1'b1;
          end
        end
      end
      DRAIN: begin
        v_d   = 1'b1;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(D - 1)) begin
          state_d = RUN;
          cnt_d   = '0;
          pend_d  = 1'b0;
        end
      end
      default: state_d = RUN;
    endcase
  end

  assign re_rnd   = (EW + 1)'(res.re) + (EW + 1)'(1);
  assign im_rnd   = (EW + 1)'(res.im) + (EW + 1)'(1);
  assign out_re_d = (SCALE != 0) ? OUT_W'(re_rnd >>> 1) : OUT_W'(res.re);
  assign out_im_d = (SCALE != 0) ? OUT_W'(im_rnd >>> 1) : OUT_W'(res.im);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= RUN;
      cnt_q       <= '0;
      pend_q      <= 1'b0;
      out_valid_q <= 1'b0;
      out_sof_q   <= 1'b0;
      err_sync_q  <= 1'b0;
      out_re_q    <= '0;
      out_im_q    <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      pend_q      <= pend_d;
      out_valid_q <= v_d;
      out_sof_q   <= sof_d;
      err_sync_q  <= err_d;
      if (v_d) begin
        out_re_q <= out_re_d;
        out_im_q <= out_im_d;
      end
    end
  end

  assign out_valid = out_valid_q;
  assign out_sof   = out_sof_q;
  assign err_sync  = err_sync_q;
  assign out_re    = out_re_q;
  assign out_im    = out_im_q;

endmodule

// File: tb/tb_r2sdf_bf_stage.sv
// Bench for r2sdf_bf_stage: unscaled and scaled instances share one stimulus stream and are
// checked every cycle against a frame-level reference model.
module tb_r2sdf_bf_stage;

  localparam int DW = 16;
  localparam int D  = 2;

  logic clk = 1'b0;
  logic rst, in_valid, in_sof, flush;
  logic signed [DW-1:0] in_re, in_im;

  logic in_ready0, out_valid0, out_sof0, err0;
  logic signed [DW:0] out_re0, out_im0;
  logic in_ready1, out_valid1, out_sof1, err1;
  logic signed [DW-1:0] out_re1, out_im1;

  always #5 clk = ~clk;

  r2sdf_bf_stage #(.DATA_WIDTH(DW), .N_POINTS(4), .STAGE(0), .SCALE(0)) dut0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready0), .in_sof(in_sof),
    .in_re(in_re), .in_im(in_im), .flush(flush), .out_valid(out_valid0), .out_sof(out_sof0),
    .out_re(out_re0), .out_im(out_im0), .err_sync(err0));

  r2sdf_bf_stage #(.DATA_WIDTH(DW), .N_POINTS(4), .STAGE(0), .SCALE(1)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready1), .in_sof(in_sof),
    .in_re(in_re), .in_im(in_im), .flush(flush), .out_valid(out_valid1), .out_sof(out_sof1),
    .out_re(out_re1), .out_im(out_im1), .err_sync(err1));

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: current frame samples, differences of the last complete frame.
  bit m_drain, m_pend;
  int m_dcnt, m_k;
  int f_re[D], f_im[D], d_re[D], d_im[D], nd_re[D], nd_im[D];
  int cap0_q[$], cap1_q[$], exp_q[$];
  int tb_pos;

  task automatic check_eq(input string tag, input longint got, input longint exp);
    n_cmp++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int scl(input int v);
    int e;
    logic signed [DW-1:0] t;
    e = (v + 1) >>> 1;
    t = e[DW-1:0];
    return int'(t);
  endfunction

  task automatic tick(input bit v, input bit sof, input int re, input int im, input bit fl,
                      output bit acc);
    bit ev, es, ee, rdy;
    int er, ei, j;
    @(negedge clk);
    in_valid = v; in_sof = sof; in_re = DW'(re); in_im = DW'(im); flush = fl;
    #1;
    rdy = !m_drain && !(fl && m_k == 0 && m_pend);
    check_eq("in_ready0", in_ready0, rdy);
    check_eq("in_ready1", in_ready1, rdy);
    acc = v && rdy;
    ev = 0; es = 0; ee = 0; er = 0; ei = 0;
    if (m_drain) begin
      ev = 1; er = d_re[m_dcnt]; ei = d_im[m_dcnt];
      m_dcnt++;
      if (m_dcnt == D) begin m_drain = 0; m_pend = 0; end
    end else if (!rdy) begin
      m_drain = 1; m_dcnt = 0;
    end else if (v) begin
      if (sof && m_k != 0) begin ee = 1; m_k = 0; m_pend = 0; end
      if (m_k < D) begin
        if (m_pend) begin ev = 1; er = d_re[m_k]; ei = d_im[m_k]; end
        f_re[m_k] = re; f_im[m_k] = im;
      end else begin
        j = m_k - D;
        ev = 1; es = (j == 0);
        er = f_re[j] + re; ei = f_im[j] + im;
        nd_re[j] = f_re[j] - re; nd_im[j] = f_im[j] - im;
        if (m_k == 2 * D - 1) begin d_re = nd_re; d_im = nd_im; m_pend = 1; end
      end
      m_k = (m_k + 1) % (2 * D);
    end
    @(posedge clk);
    #1;
    check_eq("out_valid0", out_valid0, ev);
    check_eq("out_valid1", out_valid1, ev);
    check_eq("out_sof0", out_sof0, es);
    check_eq("out_sof1", out_sof1, es);
    check_eq("err_sync0", err0, ee);
    check_eq("err_sync1", err1, ee);
    if (ev) begin
      check_eq("out_re0", out_re0, er);
      check_eq("out_im0", out_im0, ei);
      check_eq("out_re1", out_re1, scl(er));
      check_eq("out_im1", out_im1, scl(ei));
      cap0_q.push_back(int'(out_re0));
      cap1_q.push_back(int'(out_re1));
    end
  endtask

  task automatic send(input bit sof, input int re, input int im, input bit fl, input int maxgap);
    bit acc;
    int tries;
    repeat ($urandom_range(0, maxgap)) tick(0, 0, 0, 0, fl, acc);
    acc = 0; tries = 0;
    while (!acc && tries < 8) begin
      tick(1, sof, re, im, fl, acc);
      tries++;
    end
    if (!acc) check_eq("accept_timeout", in_ready0, 1);
  endtask

  task automatic frame4(input int r0, input int r1, input int r2, input int r3, input int maxgap);
    send(1, r0, 0, 0, maxgap);
    send(0, r1, 0, 0, maxgap);
    send(0, r2, 0, 0, maxgap);
    send(0, r3, 0, 0, maxgap);
  endtask

  task automatic do_flush();
    bit acc;
    repeat (D + 2) tick(0, 0, 0, 0, 1, acc);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 0; in_valid = 0; in_sof = 0; flush = 0; in_re = '0; in_im = '0;
    #1;
    check_eq("rst_valid0", out_valid0, 0);
    check_eq("rst_valid1", out_valid1, 0);
    check_eq("rst_sof0", out_sof0, 0);
    check_eq("rst_err0", err0, 0);
    check_eq("rst_re0", out_re0, 0);
    check_eq("rst_im0", out_im0, 0);
    check_eq("rst_re1", out_re1, 0);
    check_eq("rst_ready0", in_ready0, 1);
    check_eq("rst_ready1", in_ready1, 1);
    m_drain = 0; m_pend = 0; m_dcnt = 0; m_k = 0;
    cap0_q.delete(); cap1_q.delete();
    @(negedge clk);
    rst = 1;
  endtask

  task automatic check_cap(input string tag, input bit which);
    int q[$];
    if (which) q = cap1_q; else q = cap0_q;
    check_eq({tag, "_len"}, q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < q.size(); i++) check_eq(tag, q[i], exp_q[i]);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit acc;
    bit sof, fl;
    rst = 0; in_valid = 0; in_sof = 0; flush = 0; in_re = '0; in_im = '0;
    do_reset();

    frame4(1, 2, 3, 4, 0);
    do_flush();
    check_eq("t1_ready", in_ready0, 1);
    exp_q = '{4, 6, -2, -2};
    check_cap("t1", 0);

    do_reset();
    frame4(1, 2, 3, 4, 0);
    frame4(5, 6, 7, 9, 0);
    do_flush();
    exp_q = '{4, 6, -2, -2, 12, 15, -2, -3};
    check_cap("t2", 0);

    do_reset();
    frame4(32767, 32767, 32767, 32767, 0);
    frame4(-32768, -32768, -32768, -32768, 0);
    frame4(3, 1, 0, 1, 0);
    exp_q = '{32767, 32767, 0, 0, -32768, -32768, 0, 0, 2, 1};
    check_cap("t3", 1);

    do_reset();
    frame4(1, 2, 3, 4, 3);
    do_flush();
    exp_q = '{4, 6, -2, -2};
    check_cap("t4", 0);

    do_reset();
    frame4(1, 2, 3, 4, 0);
    send(1, 10, 0, 0, 0);
    send(1, 20, 0, 0, 0);
    send(0, 30, 0, 0, 0);
    send(0, 40, 0, 0, 0);
    send(0, 50, 0, 0, 0);
    do_flush();
    exp_q = '{4, 6, -2, 60, 80, -20, -20};
    check_cap("t5", 0);

    do_reset();
    frame4(1, 2, 3, 4, 0);
    tick(0, 0, 0, 0, 1, acc);
    tick(0, 0, 0, 0, 1, acc);
    do_reset();
    frame4(1, 2, 3, 4, 0);
    exp_q = '{4, 6};
    check_cap("t6", 0);

    do_reset();
    tb_pos = 0;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 149) == 0) begin
        do_reset();
        tb_pos = 0;
      end
      sof = ($urandom_range(0, 19) == 0) ? 1'b1 : (tb_pos == 0);
      fl  = ($urandom_range(0, 5) == 0);
      send(sof, int'($urandom_range(0, 65535)) - 32768, int'($urandom_range(0, 65535)) - 32768,
           fl, 2);
      tb_pos = sof ? 1 : (tb_pos + 1) % 4;
    end
    do_flush();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
